// File: rtl/instr_prefetch_pkg.sv
// Shared definitions for the instruction prefetch block.
//   XLEN             - datapath / address width
//   PC_STEP          - byte increment between sequential instructions
//   prefetch_entry_t - one buffered entry: instruction address and word
package instr_prefetch_pkg;

    localparam int XLEN    = 32;
    localparam int PC_STEP = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } prefetch_entry_t;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO holding prefetched {pc, instr} entries.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   push, pop   - enqueue wr_entry / dequeue head (ignored when impossible)
//   flush       - drop every entry; overrides push and pop
//   wr_entry    - entry written at the tail on push
//   count       - number of buffered entries, 0..DEPTH
//   head        - oldest entry, all zeros when empty
//   full        - count == DEPTH
module instr_fifo
    import instr_prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  prefetch_entry_t          wr_entry,
    output logic [$clog2(DEPTH):0]   count,
    output prefetch_entry_t          head,
    output logic                     full
);

    localparam int               PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);

    prefetch_entry_t  mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             empty;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign pop_ok  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);

    // Pointers are PTR_W bits wide, so DEPTH being a power of two makes
    // the +1 wrap modulo DEPTH for free.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            // NOTE: non-blocking assignments for all state, so every register
            // samples the pre-edge values regardless of statement order.
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; an entry is never observed before it is
    // written because head is masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok && !reset && !flush) mem[wr_ptr] <= wr_entry;
    end

    assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch stage: streams sequential words from a combinational
// instruction ROM into a small FIFO feeding decode, with redirect support.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   imem_addr       - byte address to the ROM (the fetch PC)
//   imem_data       - ROM word for imem_addr, same cycle
//   redirect_valid  - flush buffered entries and restart fetch at redirect_pc
//   redirect_pc     - redirect target byte address (low two bits dropped)
//   instr_valid     - head entry valid toward decode
//   instr_ready     - decode accepts the head entry
//   instr_data      - head instruction word (0 when empty)
//   instr_pc        - head instruction address (0 when empty)
//   fifo_count      - number of buffered entries
module instr_prefetch
    import instr_prefetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [XLEN-1:0]        imem_addr,
    input  logic [XLEN-1:0]        imem_data,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [XLEN-1:0]        instr_data,
    output logic [XLEN-1:0]        instr_pc,
    output logic [$clog2(DEPTH):0] fifo_count
);

    logic [XLEN-1:0]          fetch_pc;
    logic [$clog2(DEPTH):0]   count;
    prefetch_entry_t          head;
    prefetch_entry_t          wr_entry;
    logic                     full;
    logic                     push;
    logic                     pop;

    // Outputs are forced idle while reset is held, even before the first
    // reset edge has cleared the FIFO state.
    assign instr_valid = !reset && (count != '0);
    assign instr_data  = instr_valid ? head.instr : '0;
    assign instr_pc    = instr_valid ? head.pc    : '0;
    assign fifo_count  = reset ? '0 : count;

    // Redirect outranks everything: no transfer happens in a redirect cycle.
    assign pop  = instr_valid && instr_ready && !redirect_valid;
    assign push = !reset && !redirect_valid && (!full || pop);

    assign imem_addr = fetch_pc;
    assign wr_entry  = '{pc: fetch_pc, instr: imem_data};

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & ~XLEN'(3);
        end else if (push) begin
            // Natural 32-bit overflow gives the required wrap to zero.
            fetch_pc <= fetch_pc + XLEN'(PC_STEP);
        end
    end

    instr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .flush    (redirect_valid),
        .wr_entry (wr_entry),
        .count    (count),
        .head     (head),
        .full     (full)
    );

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed self-checking bench for instr_prefetch. Two instances: one with
// RESET_PC=0 for the main scenarios, one with RESET_PC=FFFF_FFF8 for wrap.
module tb_instr_prefetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ROM contents: a recognisable word derived from the word address.
    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        logic [31:0] widx;
        widx = addr >> 2;
        return {16'hC0DE, widx[15:0]};
    endfunction

    // Instance A (RESET_PC = 0)
    logic        reset_a, redirect_valid_a, instr_ready_a, instr_valid_a;
    logic [31:0] imem_addr_a, imem_data_a, redirect_pc_a, instr_data_a, instr_pc_a;
    logic [2:0]  fifo_count_a;
    assign imem_data_a = rom_word(imem_addr_a);

    instr_prefetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut_a (
        .clk            (clk),
        .reset          (reset_a),
        .imem_addr      (imem_addr_a),
        .imem_data      (imem_data_a),
        .redirect_valid (redirect_valid_a),
        .redirect_pc    (redirect_pc_a),
        .instr_valid    (instr_valid_a),
        .instr_ready    (instr_ready_a),
        .instr_data     (instr_data_a),
        .instr_pc       (instr_pc_a),
        .fifo_count     (fifo_count_a)
    );

    // Instance B (RESET_PC = FFFF_FFF8)
    logic        reset_b, redirect_valid_b, instr_ready_b, instr_valid_b;
    logic [31:0] imem_addr_b, imem_data_b, redirect_pc_b, instr_data_b, instr_pc_b;
    logic [2:0]  fifo_count_b;
    assign imem_data_b = rom_word(imem_addr_b);

    instr_prefetch #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_b (
        .clk            (clk),
        .reset          (reset_b),
        .imem_addr      (imem_addr_b),
        .imem_data      (imem_data_b),
        .redirect_valid (redirect_valid_b),
        .redirect_pc    (redirect_pc_b),
        .instr_valid    (instr_valid_b),
        .instr_ready    (instr_ready_b),
        .instr_data     (instr_data_b),
        .instr_pc       (instr_pc_b),
        .fifo_count     (fifo_count_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are observed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset instance A for two edges, then release.
    task automatic reset_and_release_a(input logic ready);
        reset_a = 1'b1; redirect_valid_a = 1'b0; instr_ready_a = 1'b0;
        step(); step();
        reset_a = 1'b0; instr_ready_a = ready;
    endtask

    initial begin
        reset_a = 1'b1; redirect_valid_a = 1'b0; redirect_pc_a = '0; instr_ready_a = 1'b0;
        reset_b = 1'b1; redirect_valid_b = 1'b0; redirect_pc_b = '0; instr_ready_b = 1'b1;
        #1;

        // Reset state
        step(); step();
        check("rst_valid", 32'(instr_valid_a), 32'd0);
        check("rst_count", 32'(fifo_count_a), 32'd0);
        check("rst_data",  instr_data_a, 32'd0);
        check("rst_pc",    instr_pc_a,   32'd0);
        check("rst_addr",  imem_addr_a,  32'd0);

        // Streaming with decode always ready: one entry in flight, pc 0,4,8...
        reset_a = 1'b0; instr_ready_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("stream_valid%0d", i), 32'(instr_valid_a), 32'd1);
            check($sformatf("stream_pc%0d", i),    instr_pc_a,   32'(4 * i));
            check($sformatf("stream_data%0d", i),  instr_data_a, rom_word(32'(4 * i)));
            check($sformatf("stream_cnt%0d", i),   32'(fifo_count_a), 32'd1);
        end

        // Decode stalled for 10 cycles: fills to 4, fetch holds at 16, head stays pc 0
        reset_and_release_a(1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("fill_cnt%0d", i), 32'(fifo_count_a), (i < 3) ? 32'(i + 1) : 32'd4);
            check($sformatf("fill_pc%0d", i),  instr_pc_a, 32'd0);
        end
        check("full_addr", imem_addr_a,  32'd16);
        check("full_data", instr_data_a, rom_word(32'd0));

        // Full with one pop: pc 0 leaves, pc 16 enters, count stays 4
        instr_ready_a = 1'b1;
        step();
        instr_ready_a = 1'b0;
        check("fullpop_cnt",  32'(fifo_count_a), 32'd4);
        check("fullpop_pc",   instr_pc_a,  32'd4);
        check("fullpop_addr", imem_addr_a, 32'd20);
        // Drain to confirm the pushed entry is pc 16 with its ROM word
        instr_ready_a = 1'b1;
        step(); step(); step();
        instr_ready_a = 1'b0;
        check("drain_pc",   instr_pc_a,   32'd16);
        check("drain_data", instr_data_a, rom_word(32'd16));

        // Redirect to 0x26 with 3 entries buffered (decode ready, full ignored)
        reset_and_release_a(1'b0);
        step(); step(); step();
        check("pre_redir_cnt", 32'(fifo_count_a), 32'd3);
        redirect_valid_a = 1'b1; redirect_pc_a = 32'h0000_0026; instr_ready_a = 1'b1;
        step();
        redirect_valid_a = 1'b0;
        check("redir_valid", 32'(instr_valid_a), 32'd0);
        check("redir_cnt",   32'(fifo_count_a), 32'd0);
        check("redir_addr",  imem_addr_a, 32'h24);
        instr_ready_a = 1'b0;
        step();
        check("redir_pc",   instr_pc_a,   32'h24);
        check("redir_data", instr_data_a, rom_word(32'h24));

        // Back-to-back redirects: last target wins
        redirect_valid_a = 1'b1; redirect_pc_a = 32'h0000_0100;
        step();
        redirect_pc_a = 32'h0000_0203;
        step();
        redirect_valid_a = 1'b0;
        check("redir2_addr", imem_addr_a, 32'h200);
        check("redir2_cnt",  32'(fifo_count_a), 32'd0);
        step();
        check("redir2_pc",   instr_pc_a, 32'h200);

        // Reset mid-stream with 2 buffered entries and a simultaneous redirect
        reset_and_release_a(1'b0);
        step(); step();
        check("pre_rst_cnt", 32'(fifo_count_a), 32'd2);
        reset_a = 1'b1; redirect_valid_a = 1'b1; redirect_pc_a = 32'h0000_0400;
        #1;
        check("in_rst_valid", 32'(instr_valid_a), 32'd0);
        check("in_rst_cnt",   32'(fifo_count_a), 32'd0);
        step();
        check("midrst_cnt",   32'(fifo_count_a), 32'd0);
        check("midrst_valid", 32'(instr_valid_a), 32'd0);
        check("midrst_addr",  imem_addr_a, 32'd0);
        reset_a = 1'b0; redirect_valid_a = 1'b0;
        step();
        check("restart_valid", 32'(instr_valid_a), 32'd1);
        check("restart_pc",    instr_pc_a, 32'd0);

        // Instance B: fetch address wraps past the top of memory
        reset_b = 1'b0;
        step();
        check("wrap_pc0", instr_pc_b, 32'hFFFF_FFF8);
        check("wrap_d0",  instr_data_b, rom_word(32'hFFFF_FFF8));
        step();
        check("wrap_pc1", instr_pc_b, 32'hFFFF_FFFC);
        step();
        check("wrap_pc2", instr_pc_b, 32'h0000_0000);
        check("wrap_d2",  instr_data_b, rom_word(32'h0000_0000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
